ozphy_poll_ctrl: RTL and testbench

OZPHY_POLL_CTRL -- requirements
Module: ozphy_poll_ctrl

---
 rtl/ozphy_poll_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ozphy_poll_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ozphy_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ozphy_poll_ctrl
// Description : Multi-lane link-training controller. Each lane walks through
//               receiver detect and the two polling states while sending
//               TS1/TS2 ordered sets, then enters L0 (logical idle).
//               link_up reports that every lane has reached L0.
// Revision    : 1.0 - initial release
// ============================================================================
module ozphy_poll_ctrl #(
  parameter int          NLANES  = 16,
  parameter int          NTS     = 1024,
  parameter int          NTS2    = 16,
  parameter int          NRX     = 8,
  parameter int          TIMEOUT = 24000,
  parameter logic [7:0]  NFTS    = 8'h20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NLANES-1:0]     txdetectrx,
  input  logic [2*NLANES-1:0]   powerdown,
  input  logic [NLANES-1:0]     rx_ts_pulse,
  input  logic [NLANES-1:0]     rx_ts_type,
  output logic [NLANES-1:0]     phystatus,
  output logic [3*NLANES-1:0]   rxstatus,
  output logic [NLANES-1:0]     rxelecidle,
  output logic [8*NLANES-1:0]   txdata,
  output logic [NLANES-1:0]     txdatak,
  output logic [NLANES-1:0]     txvalid,
  output logic [3*NLANES-1:0]   ltssm_state,
  output logic                  link_up
);

  // One sent counter serves both polling states, so it is sized for the larger limit.
  localparam int SENT_MAX = (NTS > NTS2) ? NTS : NTS2;
  localparam int SENT_W   = $clog2(SENT_MAX + 1);
  localparam int RCV_W    = $clog2(NRX + 1);
  localparam int TMR_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    DETECT_QUIET   = 3'd0,
    DETECT_ACTIVE  = 3'd1,
    POLLING_ACTIVE = 3'd2,
    POLLING_CONFIG = 3'd3,
    L0             = 3'd4
  } state_t;

  // Ordered-set symbol table: returns {K flag, data byte} for symbol index idx.
  function automatic logic [8:0] ts_sym(input logic [3:0] idx, input logic ts2);
    logic [8:0] s;
    case (idx)
      4'd0:       s = {1'b1, 8'hBC};
      4'd1, 4'd2: s = {1'b1, 8'hF7};
      4'd3:       s = {1'b0, NFTS};
      4'd4:       s = {1'b0, 8'h02};
      4'd5:       s = {1'b0, 8'h00};
      default:    s = {1'b0, (ts2 ? 8'h45 : 8'h4A)};
    endcase
    return s;
  endfunction

  logic [NLANES-1:0] in_l0;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    state_t            state;
    logic [3:0]        sym;
    logic [SENT_W-1:0] sent;
    logic [RCV_W-1:0]  rcv;
    logic [TMR_W-1:0]  tmr;
    logic              phy_q;
    logic [2:0]        rxs_q;
    logic              eidle_q;
    logic [7:0]        txd_q;
    logic              txk_q;
    logic              txv_q;

    logic              in_poll;
    logic              pd_nz;
    logic              rx_hit;
    logic              last_sym;
    int                sent_lim;
    logic              sent_done;
    logic              rcv_done;
    logic              exit_ok;
    logic              tmo;
    logic              go_quiet;
    logic [8:0]        cur_sym;

    assign in_poll   = (state == POLLING_ACTIVE) || (state == POLLING_CONFIG);
    assign pd_nz     = |powerdown[2*i +: 2];
    // Polling-active accepts any partner set; polling-config only counts TS2.
    assign rx_hit    = rx_ts_pulse[i] &&
                       ((state == POLLING_ACTIVE) ||
                        ((state == POLLING_CONFIG) && rx_ts_type[i]));
    assign last_sym  = (sym == 4'd15);
    assign sent_lim  = (state == POLLING_ACTIVE) ? NTS : NTS2;
    // Both "done" terms include the set/pulse being handled in this cycle.
    assign sent_done = (int'(sent) + 1) >= sent_lim;
    assign rcv_done  = (int'(rcv) + int'(rx_hit)) >= NRX;
    assign exit_ok   = in_poll && last_sym && sent_done && rcv_done;
    assign tmo       = in_poll && (int'(tmr) == TIMEOUT - 1);
    // Power-down outranks everything; a timeout loses to a same-cycle exit.
    assign go_quiet  = ((in_poll || (state == L0)) && pd_nz) || (tmo && !exit_ok);
    assign cur_sym   = ts_sym(sym, state == POLLING_CONFIG);

    // Per-lane training FSM with registered PIPE-side outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= DETECT_QUIET;
        sym     <= '0;
        sent    <= '0;
        rcv     <= '0;
        tmr     <= '0;
        phy_q   <= 1'b0;
        rxs_q   <= 3'd0;
        eidle_q <= 1'b1;
        txd_q   <= 8'h00;
        txk_q   <= 1'b0;
        txv_q   <= 1'b0;
      end else begin
        phy_q <= 1'b0;
        rxs_q <= 3'd0;
        if (go_quiet) begin
          state   <= DETECT_QUIET;
          sym     <= '0;
          sent    <= '0;
          rcv     <= '0;
          tmr     <= '0;
          eidle_q <= 1'b1;
          txd_q   <= 8'h00;
          txk_q   <= 1'b0;
          txv_q   <= 1'b0;
        end else begin
          case (state)
            DETECT_QUIET: begin
              eidle_q <= 1'b1;
              txd_q   <= 8'h00;
              txk_q   <= 1'b0;
              txv_q   <= 1'b0;
              if (txdetectrx[i]) begin
                state <= DETECT_ACTIVE;
                rxs_q <= 3'd3;
                phy_q <= 1'b1;
              end
            end
            DETECT_ACTIVE: begin
              if (!pd_nz) begin
                state   <= POLLING_ACTIVE;
                phy_q   <= 1'b1;
                eidle_q <= 1'b0;
                sym     <= '0;
                sent    <= '0;
                rcv     <= '0;
                tmr     <= '0;
              end
            end
            POLLING_ACTIVE, POLLING_CONFIG: begin
              txd_q <= cur_sym[7:0];
              txk_q <= cur_sym[8];
              txv_q <= 1'b1;
              sym   <= sym + 4'd1;
              tmr   <= tmr + TMR_W'(1);
              if (rx_hit && (int'(rcv) < NRX))
                rcv <= rcv + RCV_W'(1);
              if (last_sym && (int'(sent) < sent_lim))
                sent <= sent + SENT_W'(1);
              if (exit_ok) begin
                state <= (state == POLLING_ACTIVE) ? POLLING_CONFIG : L0;
                sym   <= '0;
                sent  <= '0;
                rcv   <= '0;
                tmr   <= '0;
              end
            end
            L0: begin
              txd_q <= 8'h00;
              txk_q <= 1'b0;
              txv_q <= 1'b1;
            end
            default: state <= DETECT_QUIET;
          endcase
        end
      end
    end

    assign phystatus[i]           = phy_q;
    assign rxstatus[3*i +: 3]     = rxs_q;
    assign rxelecidle[i]          = eidle_q;
    assign txdata[8*i +: 8]       = txd_q;
    assign txdatak[i]             = txk_q;
    assign txvalid[i]             = txv_q;
    assign ltssm_state[3*i +: 3]  = state;
    assign in_l0[i]               = (state == L0);
  end

  // link_up trails the all-lanes-in-L0 condition by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) link_up <= 1'b0;
    else       link_up <= &in_l0;
  end

endmodule
`default_nettype wire

// File: tb/tb_ozphy_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ozphy_poll_ctrl
// Description : Scoreboard bench for ozphy_poll_ctrl (4 lanes, short limits).
//               Lane 0 output records are queued by the stimulus and popped
//               by a monitor whenever lane 0 strobes phystatus or txvalid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ozphy_poll_ctrl;
  localparam int NL = 4;

  logic              clk;
  logic              reset;
  logic [NL-1:0]     txdetectrx;
  logic [2*NL-1:0]   powerdown;
  logic [NL-1:0]     rx_ts_pulse;
  logic [NL-1:0]     rx_ts_type;
  logic [NL-1:0]     phystatus;
  logic [3*NL-1:0]   rxstatus;
  logic [NL-1:0]     rxelecidle;
  logic [8*NL-1:0]   txdata;
  logic [NL-1:0]     txdatak;
  logic [NL-1:0]     txvalid;
  logic [3*NL-1:0]   ltssm_state;
  logic              link_up;

  // {phystatus, rxstatus, txdata, txdatak, txvalid, state, rxelecidle} of lane 0
  typedef struct packed {
    logic       phy;
    logic [2:0] rxs;
    logic [7:0] txd;
    logic       txk;
    logic       txv;
    logic [2:0] st;
    logic       eidle;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_rec = 0;

  ozphy_poll_ctrl #(
    .NLANES (NL),
    .NTS    (4),
    .NTS2   (2),
    .NRX    (2),
    .TIMEOUT(200),
    .NFTS   (8'h20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .txdetectrx (txdetectrx),
    .powerdown  (powerdown),
    .rx_ts_pulse(rx_ts_pulse),
    .rx_ts_type (rx_ts_type),
    .phystatus  (phystatus),
    .rxstatus   (rxstatus),
    .rxelecidle (rxelecidle),
    .txdata     (txdata),
    .txdatak    (txdatak),
    .txvalid    (txvalid),
    .ltssm_state(ltssm_state),
    .link_up    (link_up)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic phy, input logic [2:0] rxs, input logic [7:0] txd,
                      input logic txk, input logic txv, input logic [2:0] st, input logic eidle);
    rec_t r;
    r = {phy, rxs, txd, txk, txv, st, eidle};
    exp_q.push_back(r);
  endtask

  // Hand-written ordered set: BC F7 F7 20 02 00 then 4A (TS1) or 45 (TS2).
  task automatic push_sym(input int s, input logic ts2, input logic [2:0] st);
    logic [7:0] b;
    logic       k;
    case (s)
      0:       begin b = 8'hBC; k = 1'b1; end
      1, 2:    begin b = 8'hF7; k = 1'b1; end
      3:       begin b = 8'h20; k = 1'b0; end
      4:       begin b = 8'h02; k = 1'b0; end
      5:       begin b = 8'h00; k = 1'b0; end
      default: begin b = ts2 ? 8'h45 : 8'h4A; k = 1'b0; end
    endcase
    push(1'b0, 3'd0, b, k, 1'b1, st, 1'b0);
  endtask

  task automatic push_set(input logic ts2, input logic [2:0] st, input logic [2:0] st_last);
    for (int s = 0; s < 16; s++) push_sym(s, ts2, (s == 15) ? st_last : st);
  endtask

  task automatic pulse(input int lane, input logic ts2);
    rx_ts_pulse[lane] = 1'b1;
    rx_ts_type[lane]  = ts2;
    @(negedge clk);
    rx_ts_pulse[lane] = 1'b0;
    rx_ts_type[lane]  = 1'b0;
  endtask

  task automatic wait_st(input int lane, input logic [2:0] st, input int bound, input string name);
    int n;
    n = 0;
    while ((ltssm_state[3*lane +: 3] !== st) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check(name, ltssm_state[3*lane +: 3], st);
  endtask

  task automatic wait_empty(input int bound, input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phystatus"},  phystatus,   0);
    check({tag, "_rxstatus"},   rxstatus,    0);
    check({tag, "_rxelecidle"}, rxelecidle,  4'hF);
    check({tag, "_txdata"},     txdata,      0);
    check({tag, "_txdatak"},    txdatak,     0);
    check({tag, "_txvalid"},    txvalid,     0);
    check({tag, "_ltssm"},      ltssm_state, 0);
    check({tag, "_link_up"},    link_up,     0);
  endtask

  // Monitor: pop and compare one record per lane-0 strobe while records are pending.
  always @(negedge clk) begin : mon
    rec_t act;
    rec_t e;
    if (!reset && (phystatus[0] || txvalid[0]) && (exp_q.size() > 0)) begin
      act = {phystatus[0], rxstatus[2:0], txdata[7:0], txdatak[0], txvalid[0],
             ltssm_state[2:0], rxelecidle[0]};
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL lane0_stream[%0d]: got phy=%b rxs=%0d txd=%h k=%b v=%b st=%0d idle=%b, expected phy=%b rxs=%0d txd=%h k=%b v=%b st=%0d idle=%b",
                 n_rec, act.phy, act.rxs, act.txd, act.txk, act.txv, act.st, act.eidle,
                 e.phy, e.rxs, e.txd, e.txk, e.txv, e.st, e.eidle);
      end
      n_rec++;
    end
  end

  initial begin : stim
    logic seen1;
    logic done;
    reset       = 1'b1;
    txdetectrx  = '0;
    powerdown   = 8'hAA;
    rx_ts_pulse = '0;
    rx_ts_type  = '0;
    #12;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Lane 0: detect, full TS1/TS2 training, into L0.
    push(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1);
    push(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0);
    repeat (3) push_set(1'b0, 3'd2, 3'd2);
    push_set(1'b0, 3'd2, 3'd3);
    repeat (2) push_set(1'b1, 3'd3, 3'd3);
    push_set(1'b1, 3'd3, 3'd4);
    repeat (3) push(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b0);

    txdetectrx[0] = 1'b1;
    @(negedge clk);
    txdetectrx[0] = 1'b0;
    repeat (2) @(negedge clk);
    powerdown[1:0] = 2'b00;
    repeat (4) @(negedge clk);
    pulse(0, 1'b0);
    repeat (3) @(negedge clk);
    pulse(0, 1'b0);
    wait_st(0, 3'd3, 200, "lane0_enter_pconfig");
    // In config: a TS1 pulse must be ignored, so the second TS2 only lands in set 3.
    repeat (2) @(negedge clk);
    pulse(0, 1'b0);
    pulse(0, 1'b1);
    repeat (29) @(negedge clk);
    pulse(0, 1'b1);
    wait_empty(300, "lane0_stream_drained");

    // Lane 1: polling without partner sets times out at cycle 200.
    txdetectrx[1] = 1'b1;
    @(negedge clk);
    txdetectrx[1]  = 1'b0;
    powerdown[3:2] = 2'b00;
    wait_st(1, 3'd2, 10, "lane1_enter_pactive");
    repeat (199) @(negedge clk);
    check("lane1_state_cyc199",   ltssm_state[5:3], 3'd2);
    check("lane1_txvalid_cyc199", txvalid[1],       1'b1);
    @(negedge clk);
    check("lane1_state_cyc200",   ltssm_state[5:3], 3'd0);
    check("lane1_eidle_cyc200",   rxelecidle[1],    1'b1);
    check("lane1_txvalid_cyc200", txvalid[1],       1'b0);
    check("lane1_txdata_cyc200",  txdata[15:8],     8'h00);

    // Lanes 1..3 trained with staggered starts; link_up waits for the last.
    powerdown = 8'h00;
    seen1 = 1'b0;
    done  = 1'b0;
    for (int cyc = 0; (cyc < 600) && !done; cyc++) begin
      txdetectrx  = (cyc == 0)  ? 4'b0010 :
                    (cyc == 20) ? 4'b0100 :
                    (cyc == 40) ? 4'b1000 : 4'b0000;
      rx_ts_pulse = ((cyc % 8) == 3) ? 4'b1110 : 4'b0000;
      rx_ts_type  = 4'b1110;
      @(negedge clk);
      if (!seen1 && (ltssm_state[5:3] == 3'd4)) begin
        seen1 = 1'b1;
        check("link_up_lane1_only", link_up, 1'b0);
      end
      if (ltssm_state == 12'o4444) begin
        check("link_up_same_cycle_all_l0", link_up, 1'b0);
        rx_ts_pulse = '0;
        @(negedge clk);
        check("link_up_after_all_l0", link_up, 1'b1);
        done = 1'b1;
      end
    end
    rx_ts_pulse = '0;
    rx_ts_type  = '0;
    txdetectrx  = '0;
    check("all_lanes_reach_l0", done, 1'b1);

    // Power-down on lane 0 in L0.
    powerdown[1:0] = 2'b10;
    @(negedge clk);
    check("pd_lane0_state",   ltssm_state[2:0], 3'd0);
    check("pd_lane0_txvalid", txvalid[0],       1'b0);
    check("pd_lane0_eidle",   rxelecidle[0],    1'b1);
    check("pd_link_up_hold",  link_up,          1'b1);
    @(negedge clk);
    check("pd_link_up_drop",  link_up,          1'b0);

    // Lane 0 retrains; reset lands in the middle of the first TS1.
    push(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1);
    push(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0);
    for (int s = 0; s < 5; s++) push_sym(s, 1'b0, 3'd2);
    txdetectrx[0] = 1'b1;
    @(negedge clk);
    txdetectrx[0]  = 1'b0;
    powerdown[1:0] = 2'b00;
    wait_empty(30, "retrain_stream_drained");
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_state",   ltssm_state, 0);
    check("post_reset_txvalid", txvalid,     0);
    check("post_reset_eidle",   rxelecidle,  4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
